life_gen_scheduler: RTL and testbench
=====================================

Name: life_gen_scheduler

Overview:
- Sequences Game of Life generation updates against the VGA raster.
- Shares the single-port cell buffer between the display reader and the life update engine.
- Sits between the sync generator (consumes hpos/vpos), the pixel/cell reader and the update engine.
- Launches a generation every FRAMES_PER_GEN frames, or on single-step. Confines engine memory access to vertical blanking, then requests a buffer swap.

Parameters:
- FRAMES_PER_GEN, 8, frames between generation launches when running (range 1..2^FCNT_W).
- FCNT_W, 4, frame counter width.
- V_VISIBLE, 480, first non-visible line; vblank is vpos >= V_VISIBLE.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- hpos  in  10  current pixel column from sync generator
- vpos  in  10  current line from sync generator
- enable  in  1  1 = free-run, 0 = paused
- step  in  1  single-cycle pulse; requests one generation while paused
- disp_req  in  1  display reader wants cell memory
- eng_req  in  1  update engine wants cell memory
- eng_done  in  1  single-cycle pulse; engine finished generation
- disp_gnt  out  1  display owns memory this cycle
- eng_gnt  out  1  engine owns memory this cycle
- gen_start  out  1  single-cycle pulse; engine begins a generation
- buf_swap  out  1  single-cycle pulse; swap front/back cell buffers
- busy  out  1  generation in progress (state != IDLE)
- gen_count  out  GEN_W  completed generations, wraps modulo 2^GEN_W

Behaviour:
- Reset (async, immediate): state=IDLE, frame_cnt=0, step_pending=0, gen_count=0. gen_start, buf_swap, busy, disp_gnt and eng_gnt all 0 while reset is high.
- frame_tick: internal combinational signal, true when hpos==0 && vpos==V_VISIBLE. Exactly one cycle per frame.
- vblank: vpos >= V_VISIBLE.
- step_pending:
  - Set on step while enable==0.
  - Ignored while enable==1.
  - Cleared on launch.
  - step and launch in the same cycle: launch wins, step is dropped.
- frame_cnt:
  - Increments on frame_tick only in IDLE with enable==1.
  - Held while busy or paused.
  - Returns to 0 on launch.
- Launch condition, evaluated in IDLE on frame_tick only:
  - (enable && frame_cnt==FRAMES_PER_GEN-1), or
  - (!enable && step_pending).
- FSM:
  - IDLE -> START on launch.
  - START: gen_start=1 for one cycle -> RUN.
  - RUN: waits for eng_done, then -> SWAP.
  - SWAP: buf_swap=1 for one cycle, gen_count+1 -> IDLE.
- Launch latency: gen_start asserts 1 cycle after the frame_tick cycle; buf_swap asserts 1 cycle after eng_done.
- Arbitration (combinational from registered state and inputs; grants always mutually exclusive):
  - eng_gnt = eng_req && vblank && state==RUN.
  - disp_gnt = disp_req && !eng_gnt.
  - In the visible region the display always wins.
- A generation may span several frames. The grant drops when vblank ends and resumes on the next vblank; the engine stalls without a handshake error.
- eng_done outside RUN is ignored.
- eng_req outside RUN is never granted.
- enable dropping mid-generation: the current generation completes and swaps; no further auto-launch.
- frame_tick while busy: ignored (no queued launch).

Decomposition:
- Shared package (vga_pkg), also usable by the sync generator:
  - timing constants H_VISIBLE=640, H_TOTAL=800, V_VISIBLE=480, V_TOTAL=525;
  - sched_state_t enum {IDLE, START, RUN, SWAP}.
- No sub-module needed. The arbiter is two assign lines inside the block; a standalone mem_arbiter sub-module is not warranted.

Test Plan:
- Reset mid-RUN with eng_req=1 during vblank -> eng_gnt drops to 0 in the same cycle as reset; after release busy=0, gen_count=0.
- FRAMES_PER_GEN=2, enable=1, 5 frames -> gen_start pulses on the frame_tick following every 2nd counted frame; eng_done 100 cycles after each -> buf_swap follows eng_done by 1 cycle; gen_count=2.
- enable=0, step pulse at vpos=100 -> no gen_start until the next vpos=480,hpos=0 tick, then exactly one; a second frame_tick gives no launch.
- RUN, eng_req=disp_req=1 held: vpos=479 -> disp_gnt=1, eng_gnt=0; vpos=480 -> eng_gnt=1, disp_gnt=0; vpos=0 next frame -> disp_gnt=1 again; grants never both 1.
- eng_done withheld for 3 frames -> busy stays 1, no extra gen_start, frame_cnt frozen; eng_done at vpos=500 -> buf_swap next cycle, gen_count+1.
- enable=1 with step pulses -> step_pending stays 0; eng_done while IDLE -> no buf_swap.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the generation scheduler state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_TOTAL   = 800;
    localparam int V_VISIBLE = 480;
    localparam int V_TOTAL   = 525;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        SWAP
    } sched_state_t;

endpackage

// File: rtl/life_gen_scheduler.sv
// Launches Life generations on the frame tick and arbitrates the single-port cell buffer.
// Latency: gen_start 1 cycle after the launching frame tick; buf_swap 1 cycle after eng_done.
// Backpressure: the engine is granted memory only during vblank in RUN; it stalls across frames otherwise.
//
// Ports:
//   clk, reset          pixel clock, asynchronous active-high reset
//   hpos, vpos          raster position from the sync generator
//   enable, step        free-run / paused control, single-step request pulse
//   disp_req, eng_req   memory requests from display reader and update engine
//   eng_done            engine finished the current generation
//   disp_gnt, eng_gnt   mutually exclusive memory grants
//   gen_start, buf_swap single-cycle pulses to the engine / buffer selector
//   busy, gen_count     generation in progress, completed generation count
module life_gen_scheduler #(
    parameter int FRAMES_PER_GEN = 8,
    parameter int FCNT_W         = 4,
    parameter int V_VISIBLE      = vga_pkg::V_VISIBLE,
    parameter int GEN_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       hpos,
    input  logic [9:0]       vpos,
    input  logic             enable,
    input  logic             step,
    input  logic             disp_req,
    input  logic             eng_req,
    input  logic             eng_done,
    output logic             disp_gnt,
    output logic             eng_gnt,
    output logic             gen_start,
    output logic             buf_swap,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count
);

    import vga_pkg::*;

    localparam logic [FCNT_W-1:0] LAST_FRAME = FCNT_W'(FRAMES_PER_GEN - 1);
    localparam logic [9:0]        VBLANK_LINE = 10'(V_VISIBLE);

    sched_state_t      state;
    logic [FCNT_W-1:0] frame_cnt;
    logic              step_pending;

    logic frame_tick;
    logic vblank;
    logic launch;

    // First pixel of the first blanked line: exactly one cycle per frame.
    assign frame_tick = (hpos == 10'd0) && (vpos == VBLANK_LINE);
    assign vblank     = (vpos >= VBLANK_LINE);

    // Launches are only considered at the frame tick, so a request made
    // mid-frame waits for the start of the next vblank window.
    assign launch = (state == IDLE) && frame_tick &&
                    (enable ? (frame_cnt == LAST_FRAME) : step_pending);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            step_pending <= 1'b0;
            gen_count    <= '0;
            gen_start    <= 1'b0;
            buf_swap     <= 1'b0;
        end else begin
            gen_start <= 1'b0;
            buf_swap  <= 1'b0;

            // A step coinciding with a launch is consumed by that launch.
            if (launch) begin
                step_pending <= 1'b0;
            end else if (step && !enable) begin
                step_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= START;
                        gen_start <= 1'b1;
                        frame_cnt <= '0;
                    end else if (frame_tick && enable) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
                START: state <= RUN;
                RUN: begin
                    if (eng_done) begin
                        state    <= SWAP;
                        buf_swap <= 1'b1;
                    end
                end
                SWAP: begin
                    state     <= IDLE;
                    gen_count <= gen_count + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Engine only touches memory in vblank; the display wins everywhere else.
    assign eng_gnt  = eng_req && vblank && (state == RUN);
    assign disp_gnt = disp_req && !eng_gnt && !reset;

endmodule

// File: tb/tb_life_gen_scheduler.sv
// Randomized scoreboard bench for life_gen_scheduler on a compressed raster.
// Latency: n/a.
// Backpressure: n/a.
module tb_life_gen_scheduler;

    localparam int FPG = 2;
    localparam int N_CYC = 6000;
    localparam int QUIET = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos, vpos;
    logic        enable, step, disp_req, eng_req, eng_done;
    logic        disp_gnt, eng_gnt, gen_start, buf_swap, busy;
    logic [15:0] gen_count;

    life_gen_scheduler #(.FRAMES_PER_GEN(FPG), .FCNT_W(4), .V_VISIBLE(480), .GEN_W(16)) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
        .enable(enable), .step(step), .disp_req(disp_req), .eng_req(eng_req),
        .eng_done(eng_done), .disp_gnt(disp_gnt), .eng_gnt(eng_gnt),
        .gen_start(gen_start), .buf_swap(buf_swap), .busy(busy), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int cnt; } swap_t;

    int    start_q[$];
    swap_t swap_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    chk_cnt = 0;
    int    exp_cnt = 0;

    // Compressed raster: 4 pixels per line, a few representative lines per frame.
    int LINES[8] = '{0, 100, 200, 479, 480, 481, 500, 524};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected pulses whenever the DUT emits one.
    always @(negedge clk) begin
        if (chk_cnt) begin
            check("gen_count_after_swap", 32'(gen_count), 32'(exp_cnt & 16'hFFFF));
            chk_cnt = 0;
        end
        if (gen_start === 1'b1) begin
            if (start_q.size() == 0) check("unexpected_gen_start", 1, 0);
            else check("gen_start_cycle", cyc, start_q.pop_front());
        end
        if (buf_swap === 1'b1) begin
            if (swap_q.size() == 0) check("unexpected_buf_swap", 1, 0);
            else begin
                swap_t e;
                e = swap_q.pop_front();
                check("buf_swap_cycle", cyc, e.cyc);
                exp_cnt = e.cnt;
                chk_cnt = 1;
            end
        end
    end

    // Reference model: a generation is a time span [launch+1 .. done+1]
    // tracked by cycle stamps rather than by explicit states.
    bit m_active = 0;
    int m_start = -10, m_done = -1, frames = 0, gcount = 0, done_at = 0;
    bit pending = 0;
    bit rst_done = 0;

    initial begin
        int  h, li;
        bit  running, vb, tick, launch, quiet, e_gnt;

        reset = 1; enable = 0; step = 0; disp_req = 1; eng_req = 1; eng_done = 0;
        hpos = 10'd0; vpos = 10'd480;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_gen_start", gen_start, 0);
        check("rst_buf_swap", buf_swap, 0);
        check("rst_eng_gnt", eng_gnt, 0);
        check("rst_disp_gnt", disp_gnt, 0);
        check("rst_gen_count", gen_count, 0);
        vpos = 10'd0; disp_req = 0; eng_req = 0; enable = 1;
        reset = 0;

        h = 0; li = 0;
        for (int n = 0; n < N_CYC; n++) begin
            @(posedge clk); #1;
            cyc++;
            quiet = (n >= N_CYC - QUIET);
            hpos = 10'(h);
            vpos = 10'(LINES[li]);
            if (quiet) enable = 0;
            else if (h == 0 && li == 0 && $urandom_range(0, 2) == 0) enable = ($urandom_range(0, 2) != 0);
            step     = !quiet && ($urandom_range(0, 29) == 0);
            disp_req = $urandom_range(0, 1);
            eng_req  = ($urandom_range(0, 3) != 0);
            tick     = (h == 0) && (LINES[li] == 480);
            vb       = (LINES[li] >= 480);
            running  = m_active && (cyc > m_start) && (m_done < 0);
            eng_done = (running && (quiet || cyc >= done_at)) ? 1'b1 : ($urandom_range(0, 59) == 0);
            h++;
            if (h == 4) begin h = 0; li = (li + 1) % 8; end

            // Asynchronous reset while the engine holds the memory.
            if (!rst_done && cyc >= 3000 && running && vb) begin
                eng_req = 1; #1;
                check("gnt_before_reset", eng_gnt, 1);
                reset = 1; #1;
                check("reset_eng_gnt", eng_gnt, 0);
                check("reset_disp_gnt", disp_gnt, 0);
                check("reset_busy", busy, 0);
                m_active = 0; m_done = -1; m_start = -10; frames = 0; pending = 0; gcount = 0;
                start_q.delete(); swap_q.delete(); chk_cnt = 0;
                @(negedge clk);
                check("reset_gen_count", gen_count, 0);
                check("reset_gen_start", gen_start, 0);
                step = 0; hpos = 10'd1;
                reset = 0;
                rst_done = 1;
                continue;
            end

            @(negedge clk);
            e_gnt = eng_req && vb && running;
            check("busy", busy, m_active);
            check("eng_gnt", eng_gnt, e_gnt);
            check("disp_gnt", disp_gnt, disp_req && !e_gnt);

            launch = 0;
            if (running && eng_done) begin
                m_done = cyc;
                swap_q.push_back('{cyc + 1, gcount + 1});
            end else if (m_active && m_done >= 0 && cyc == m_done + 1) begin
                gcount++;
                m_active = 0;
            end else if (!m_active) begin
                launch = tick && (enable ? (frames == FPG - 1) : pending);
                if (launch) begin
                    m_active = 1; m_start = cyc + 1; m_done = -1; frames = 0;
                    start_q.push_back(cyc + 1);
                    done_at = cyc + 2 + $urandom_range(3, 90);
                end else if (tick && enable) begin
                    frames++;
                end
            end
            if (launch) pending = 0;
            else if (step && !enable) pending = 1;
        end

        @(negedge clk);
        check("reset_test_reached", rst_done, 1);
        check("leftover_gen_start", start_q.size(), 0);
        check("leftover_buf_swap", swap_q.size(), 0);
        check("final_busy", busy, m_active);
        check("final_gen_count", gen_count, gcount & 16'hFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
